// File: rtl/sdram_line_responder.sv
// SDRAM stand-in for the cache's line-burst request/ack interface: BURST_LEN-word
// read bursts, per-word write handshakes, programmable latency and a backdoor port.
module sdram_line_responder #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_LOG2   = 12,
  parameter int BURST_LEN  = 8,
  parameter int RD_LATENCY = 4,
  parameter int WR_LATENCY = 2
) (
  input  logic                  sys_clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] sdram_address,
  input  logic [DATA_WIDTH-1:0] sdram_data_write,
  output logic [DATA_WIDTH-1:0] sdram_data_read,
  input  logic                  sdram_read_req,
  input  logic                  sdram_write_req,
  output logic                  sdram_read_ack,
  output logic                  sdram_write_ack,
  output logic                  busy,
  input  logic [MEM_LOG2-1:0]   bd_address,
  input  logic [DATA_WIDTH-1:0] bd_data,
  input  logic                  bd_we,
  output logic [DATA_WIDTH-1:0] bd_q
);

  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam int WCW     = $clog2(BURST_LEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_WAIT,
    WR_GAP,
    DRAIN
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [CW-1:0]         lat_cnt;
  logic [WCW-1:0]        word_cnt;
  logic [MEM_LOG2-1:0]   addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [MEM_LOG2-1:0]   rd_idx;
  logic                  start_rd;
  logic                  start_wr;
  logic                  rd_load;
  logic                  core_we;

  logic [DATA_WIDTH-1:0] mem [0:(1 << MEM_LOG2) - 1];

  // Address bits above the backing store are deliberately ignored.
  if (ADDR_WIDTH > MEM_LOG2) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^sdram_address[ADDR_WIDTH-1:MEM_LOG2];
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every output gets a default first, so no path infers a latch.
  always_comb begin
    next_state      = state;
    sdram_read_ack  = 1'b0;
    sdram_write_ack = 1'b0;
    start_rd        = 1'b0;
    start_wr        = 1'b0;
    rd_load         = 1'b0;
    core_we         = 1'b0;
    case (state)
      IDLE: begin
        if (sdram_read_req) begin
          start_rd   = 1'b1;
          next_state = RD_WAIT;
        end else if (sdram_write_req) begin
          start_wr   = 1'b1;
          next_state = WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_cnt == CW'(RD_LATENCY)) begin
          sdram_read_ack = 1'b1;
          rd_load        = 1'b1;
          next_state     = RD_BURST;
        end
      end
      RD_BURST: begin
        // word_cnt counts words already loaded; the last one is on the bus now.
        if (word_cnt == WCW'(BURST_LEN)) begin
          next_state = DRAIN;
        end else begin
          rd_load = 1'b1;
        end
      end
      WR_WAIT: begin
        if (lat_cnt == CW'(WR_LATENCY)) begin
          sdram_write_ack = 1'b1;
          core_we         = 1'b1;
          next_state      = (word_cnt == WCW'(BURST_LEN - 1)) ? DRAIN : WR_GAP;
        end
      end
      WR_GAP: begin
        // Request/address/data were stale during the ack cycle; sample them here.
        if (sdram_write_req) begin
          start_wr   = 1'b1;
          next_state = WR_WAIT;
        end else begin
          next_state = IDLE;
        end
      end
      DRAIN: begin
        if (!sdram_read_req && !sdram_write_req) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy   = (state != IDLE);
  assign rd_idx = addr_q + MEM_LOG2'(word_cnt);

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_cnt         <= '0;
      word_cnt        <= '0;
      addr_q          <= '0;
      wr_data_q       <= '0;
      sdram_data_read <= '0;
    end else begin
      if (start_rd || start_wr) begin
        lat_cnt <= CW'(1);
        addr_q  <= sdram_address[MEM_LOG2-1:0];
      end else if (state == RD_WAIT || state == WR_WAIT) begin
        lat_cnt <= lat_cnt + CW'(1);
      end
      if (start_wr) begin
        wr_data_q <= sdram_data_write;
      end
      if (state == IDLE) begin
        word_cnt <= '0;
      end else if (rd_load || core_we) begin
        word_cnt <= word_cnt + WCW'(1);
      end
      if (rd_load) begin
        sdram_data_read <= mem[rd_idx];
      end
    end
  end

  // NOTE: storage has no reset; contents deliberately survive reset_n.
  // The core write is issued last so it wins a same-index collision.
  always_ff @(posedge sys_clk) begin
    if (bd_we) begin
      mem[bd_address] <= bd_data;
    end
    if (core_we) begin
      mem[addr_q] <= wr_data_q;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      bd_q <= '0;
    end else begin
      bd_q <= mem[bd_address];
    end
  end

endmodule

// File: tb/tb_sdram_line_responder.sv
// Directed bench for sdram_line_responder: read bursts checked against a scoreboard
// queue filled from a bench-side memory model, write bursts checked via the backdoor.
module tb_sdram_line_responder;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int ML = 12;
  localparam int BL = 8;
  localparam int RL = 4;
  localparam int WL = 2;

  logic          sys_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] sdram_address = '0;
  logic [DW-1:0] sdram_data_write = '0;
  logic [DW-1:0] sdram_data_read;
  logic          sdram_read_req = 1'b0;
  logic          sdram_write_req = 1'b0;
  logic          sdram_read_ack;
  logic          sdram_write_ack;
  logic          busy;
  logic [ML-1:0] bd_address = '0;
  logic [DW-1:0] bd_data = '0;
  logic          bd_we = 1'b0;
  logic [DW-1:0] bd_q;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model [0:(1 << ML) - 1];
  logic [DW-1:0] exp_q [$];

  sdram_line_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LOG2(ML),
    .BURST_LEN(BL), .RD_LATENCY(RL), .WR_LATENCY(WL)
  ) dut (
    .sys_clk         (sys_clk),
    .reset_n         (reset_n),
    .sdram_address   (sdram_address),
    .sdram_data_write(sdram_data_write),
    .sdram_data_read (sdram_data_read),
    .sdram_read_req  (sdram_read_req),
    .sdram_write_req (sdram_write_req),
    .sdram_read_ack  (sdram_read_ack),
    .sdram_write_ack (sdram_write_ack),
    .busy            (busy),
    .bd_address      (bd_address),
    .bd_data         (bd_data),
    .bd_we           (bd_we),
    .bd_q            (bd_q)
  );

  initial forever #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge; sets the backdoor address and checks bd_q one cycle later.
  task automatic bd_check(input logic [ML-1:0] addr, input string tag);
    bd_address = addr;
    @(negedge sys_clk);
    check($sformatf("%s_bd[%0h]", tag, addr), 32'(bd_q), 32'(model[addr]));
  endtask

  // Cycle j=0 is the request cycle. abort_word>=0 pulses reset while that word is on the bus.
  task automatic read_burst(input logic [AW-1:0] addr, input string tag,
                            input int abort_word, input bit hold_write);
    logic [DW-1:0] last;
    logic [DW-1:0] e;
    logic [ML-1:0] ix;
    bit            aborted;
    aborted = 1'b0;
    last    = '0;
    for (int k = 0; k < BL; k++) begin
      ix = addr[ML-1:0] + ML'(k);
      exp_q.push_back(model[ix]);
    end
    for (int j = 0; j <= RL + BL + 2; j++) begin
      @(negedge sys_clk);
      check($sformatf("%s_rack@%0d", tag, j), 32'(sdram_read_ack), 32'(j == RL));
      check($sformatf("%s_wack@%0d", tag, j), 32'(sdram_write_ack), 32'(0));
      check($sformatf("%s_busy@%0d", tag, j), 32'(busy),
            32'((j >= 1) && (hold_write || j <= RL + BL + 1)));
      if (j >= RL + 1 && j <= RL + BL) begin
        e    = exp_q.pop_front();
        last = e;
        check($sformatf("%s_word%0d", tag, j - RL - 1), 32'(sdram_data_read), 32'(e));
      end else if (j > RL + BL) begin
        check($sformatf("%s_hold@%0d", tag, j), 32'(sdram_data_read), 32'(last));
      end
      if (j == 0) begin
        sdram_read_req = 1'b1;
        sdram_address  = addr;
        if (hold_write) sdram_write_req = 1'b1;
      end
      if (j == RL) sdram_read_req = 1'b0;
      if (j > RL) sdram_address = AW'($urandom);
      if (abort_word >= 0 && j == RL + 1 + abort_word) begin
        reset_n = 1'b0;
        #1;
        check($sformatf("%s_rst_data", tag), 32'(sdram_data_read), 32'(0));
        check($sformatf("%s_rst_busy", tag), 32'(busy), 32'(0));
        check($sformatf("%s_rst_rack", tag), 32'(sdram_read_ack), 32'(0));
        @(negedge sys_clk);
        reset_n = 1'b1;
        exp_q.delete();
        aborted = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge sys_clk);
          check($sformatf("%s_post_busy%0d", tag, i), 32'(busy), 32'(0));
          check($sformatf("%s_post_rack%0d", tag, i), 32'(sdram_read_ack), 32'(0));
          check($sformatf("%s_post_data%0d", tag, i), 32'(sdram_data_read), 32'(0));
        end
        break;
      end
    end
    if (hold_write && !aborted) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge sys_clk);
        check($sformatf("%s_drain_busy%0d", tag, i), 32'(busy), 32'(1));
        check($sformatf("%s_drain_wack%0d", tag, i), 32'(sdram_write_ack), 32'(0));
      end
      sdram_write_req = 1'b0;
      @(negedge sys_clk);
      check($sformatf("%s_drain_exit", tag), 32'(busy), 32'(0));
    end
  endtask

  // Writes n words; the initiator updates address/data on each ack. A full burst
  // keeps write_req high for four cycles past the last ack before dropping it.
  task automatic write_burst(input logic [AW-1:0] base, input logic [DW-1:0] dbase,
                             input int n, input bit collide_first, input string tag);
    int            acks;
    int            drop_at;
    int            idle_at;
    bit            done;
    bit            coll_pending;
    bit            exp_ack;
    logic [ML-1:0] idx;
    logic [DW-1:0] coll_old;
    acks = 0; drop_at = -1; idle_at = -1; done = 1'b0; coll_pending = 1'b0; coll_old = '0;
    for (int j = 0; j < 200; j++) begin
      @(negedge sys_clk);
      exp_ack = (j >= WL) && ((j - WL) % (WL + 1) == 0) && ((j - WL) / (WL + 1) < n);
      check($sformatf("%s_wack@%0d", tag, j), 32'(sdram_write_ack), 32'(exp_ack));
      check($sformatf("%s_rack@%0d", tag, j), 32'(sdram_read_ack), 32'(0));
      if (coll_pending) begin
        check($sformatf("%s_coll_bd_q", tag), 32'(bd_q), 32'(coll_old));
        bd_we        = 1'b0;
        coll_pending = 1'b0;
      end
      if (idle_at >= 0 && j == idle_at) begin
        check($sformatf("%s_idle", tag), 32'(busy), 32'(0));
        done = 1'b1;
        break;
      end
      check($sformatf("%s_busy@%0d", tag, j), 32'(busy), 32'(j >= 1));
      if (j == 0) begin
        sdram_write_req  = 1'b1;
        sdram_address    = base;
        sdram_data_write = dbase;
      end
      if (sdram_write_ack) begin
        idx = sdram_address[ML-1:0];
        if (collide_first && acks == 0) begin
          coll_old     = model[idx];
          bd_address   = idx;
          bd_data      = ~sdram_data_write;
          bd_we        = 1'b1;
          coll_pending = 1'b1;
        end
        model[idx] = sdram_data_write;
        acks++;
        if (acks < n) begin
          sdram_address    = base + AW'(acks);
          sdram_data_write = dbase + DW'(acks);
        end else if (n < BL) begin
          sdram_write_req = 1'b0;
          idle_at         = j + 2;
        end else begin
          drop_at = j + 5;
          idle_at = j + 6;
        end
      end
      if (j == drop_at) sdram_write_req = 1'b0;
    end
    check($sformatf("%s_completed", tag), 32'(done), 32'(1));
    check($sformatf("%s_ack_count", tag), 32'(acks), 32'(n));
  endtask

  initial begin
    repeat (2) @(negedge sys_clk);
    check("reset_data", 32'(sdram_data_read), 32'(0));
    check("reset_rack", 32'(sdram_read_ack), 32'(0));
    check("reset_wack", 32'(sdram_write_ack), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_bd_q", 32'(bd_q), 32'(0));
    reset_n = 1'b1;

    for (int i = 0; i < (1 << ML); i++) begin
      bd_address = ML'(i);
      bd_data    = (i >= 'h40 && i < 'h48) ? DW'(16'h1100 + i - 'h40) : (DW'(i) ^ 16'h5A5A);
      bd_we      = 1'b1;
      model[i]   = bd_data;
      @(negedge sys_clk);
    end
    bd_we = 1'b0;

    read_burst(24'h000040, "read", -1, 1'b0);
    read_burst(24'h000300, "coll", -1, 1'b1);
    write_burst(24'h000080, 16'hA000, BL, 1'b0, "write");
    for (int k = 0; k < BL; k++) bd_check(ML'('h80 + k), "write");
    read_burst(24'h000FFC, "wrap", -1, 1'b0);
    read_burst(24'h5A3FFE, "wrap_hi", -1, 1'b0);
    read_burst(24'h000040, "rst", 2, 1'b0);
    read_burst(24'h000123, "after_rst", -1, 1'b0);
    write_burst(24'h000200, 16'hB000, 3, 1'b1, "abort");
    for (int k = 0; k < BL; k++) bd_check(ML'('h200 + k), "abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
